// File: rtl/axi_rr_arbiter.sv
// axi_rr_arbiter: round-robin AXI address-channel arbiter (req/addr/slv_ready/resp_done in; grant/owner/busy/sel/decerr/full out)
module axi_rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int NUM_S = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_OUTSTANDING = 4,
  localparam int M_W = NUM_M > 1 ? $clog2(NUM_M) : 1,
  localparam int S_W = NUM_S > 1 ? $clog2(NUM_S) : 1,
  localparam int C_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_M-1:0]            req,
  input  logic [NUM_M*ADDR_WIDTH-1:0] addr,
  input  logic                        slv_ready,
  input  logic [NUM_M-1:0]            resp_done,
  output logic [NUM_M-1:0]            grant,
  output logic [M_W-1:0]              owner,
  output logic                        busy,
  output logic [S_W-1:0]              sel,
  output logic                        decerr,
  output logic [NUM_M-1:0]            full
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0] state;
  logic [M_W-1:0] ptr, win;
  logic [NUM_M-1:0] eligible;
  logic [S_W-1:0] idx;
  logic [C_W-1:0] cnt [NUM_M];
  logic [C_W-1:0] cnt_nxt [NUM_M];
  assign busy = state == GRANT;
  assign eligible = req & ~full;
  assign idx = addr[int'(win)*ADDR_WIDTH + ADDR_WIDTH-1 -: S_W];
  always_comb begin
    win = '0;
    for (int k = NUM_M - 1; k >= 0; k--)
      if (eligible[(int'(ptr) + k) % NUM_M]) win = M_W'((int'(ptr) + k) % NUM_M);
  end
  always_comb begin
    for (int i = 0; i < NUM_M; i++) begin
      cnt_nxt[i] = cnt[i];
      cnt_nxt[i] = (grant[i] & req[i] & slv_ready) & ~(resp_done[i] & |cnt[i]) ? cnt[i] + C_W'(1) :
                   ~(grant[i] & req[i] & slv_ready) & (resp_done[i] & |cnt[i]) ? cnt[i] - C_W'(1) : cnt[i];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      sel <= '0;
      decerr <= 1'b0;
      ptr <= '0;
      full <= '0;
      for (int i = 0; i < NUM_M; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        cnt[i] <= cnt_nxt[i];
        full[i] <= cnt_nxt[i] == C_W'(MAX_OUTSTANDING);
      end
      if (state == IDLE && |eligible) begin
        state <= GRANT;
        grant <= NUM_M'(1) << win;
        owner <= win;
        sel <= idx;
        decerr <= {1'b0, idx} >= (S_W+1)'(NUM_S);
      end else if (state == GRANT && (!req[owner] || slv_ready)) begin
        state <= IDLE;
        grant <= '0;
        decerr <= 1'b0;
        ptr <= owner == M_W'(NUM_M - 1) ? '0 : owner + M_W'(1);
      end
    end
  end
endmodule

// File: doc/axi_rr_arbiter.md
# axi_rr_arbiter

Parametrised round-robin arbiter for one AXI address channel (AW or AR) of the interconnect. It serves NUM_M masters and decodes a target slave among NUM_S slaves. The grant is held until the address handshake completes, and each master's outstanding transactions are tracked against a configurable limit. One instance sits per address channel, driving the master/slave routing muxes; write-data and response routing follow the recorded owner/sel.

## Interface
Parameters:
- NUM_M, 2: number of masters (≥2).
- NUM_S, 2: number of slaves (≥1).
- ADDR_WIDTH, 32: address width.
- MAX_OUTSTANDING, 4: maximum accepted-but-unresponded transactions per master (≥1).
- Derived M_W = max(1, clog2(NUM_M)); S_W = max(1, clog2(NUM_S)); C_W = clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_M  per-master AxVALID.
- addr  in  NUM_M*ADDR_WIDTH  flattened addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- slv_ready  in  1  AxREADY of the routed slave (or of the default slave when decerr).
- resp_done  in  NUM_M  one-cycle pulse per master when its response (B, or R last) completes.
- grant  out  NUM_M  one-hot registered grant (AxREADY gating/mux select).
- owner  out  M_W  index of the granted master; valid while busy.
- busy  out  1  a grant is active.
- sel  out  S_W  decoded slave index of the granted address.
- decerr  out  1  granted address maps to no slave; route to default slave.
- full  out  NUM_M  master i has MAX_OUTSTANDING outstanding transactions.

## Operation
- Reset: grant=0, owner=0, busy=0, sel=0, decerr=0, all counters=0 (full=0), priority pointer ptr=0, state IDLE.
- eligible = req & ~full.
- IDLE: if eligible≠0, the winner is the first set bit of eligible searching ptr, ptr+1, … wrapping mod NUM_M. The search is a single cycle and may skip any number of idle masters. Register grant[winner]=1, owner=winner, busy=1. Latch idx = addr_winner[ADDR_WIDTH-1 -: S_W]; sel=idx, decerr=(idx ≥ NUM_S). Go to GRANT. If eligible=0, stay in IDLE and leave ptr unchanged.
- GRANT: sel/decerr/owner are frozen regardless of address changes.
  - Completion (req[owner] & slv_ready): counter[owner]+1, ptr=(owner+1) mod NUM_M; clear grant/busy/decerr; go to IDLE.
  - Abort (req[owner]=0 without handshake): clear grant/busy/decerr, ptr=(owner+1) mod NUM_M, no count change; go to IDLE.
- Counters: resp_done[i] decrements counter i, saturating at 0. If an increment and a decrement for the same master occur in the same cycle, the count is unchanged. full[i] = (counter[i]==MAX_OUTSTANDING), registered from the counter.
- A full master is never granted, even if it is the only requester. It becomes eligible in the cycle after its counter drops.
- Requests from non-owners while busy are ignored; no preemption.

## Timing
- Request to grant: 1 cycle. req seen in cycle N with IDLE gives grant high at N+1.
- Handshake cycle: grant, req[owner] and slv_ready all high in cycle N. grant falls at N+1, IDLE evaluates at N+1, and the next grant appears at N+2. Minimum spacing between grants is 2 cycles.
- counter/full update at the clock edge following completion or resp_done.
- Asynchronous reset mid-GRANT drops grant immediately. Counters and ptr clear; in-flight transactions are forgotten.
- sel is valid in every cycle busy=1; it is don't-care (held) otherwise.

## Test plan
- Reset and single request: assert rst low, then release; req=01, addr0=0x0000_1000, slv_ready=1 at cycle 3 → grant=01 at cycle 2, sel=0, decerr=0; grant=00 at cycle 4; counter0=1.
- Round robin: req=11 held, slv_ready=1 on each granted cycle, NUM_M=2 → grants alternate 01,10,01,10 with one idle cycle between each.
- Skip with NUM_M=4: ptr=1, req=1000 → grant=1000 in 1 cycle; after completion ptr=0.
- Outstanding limit: MAX_OUTSTANDING=2; master0 completes 2 handshakes with no resp_done → full[0]=1 and req0 is not granted. Pulse resp_done[0] → full[0]=0 next cycle, grant follows 1 cycle later. Simultaneous completion and resp_done at count 1 → count stays 1.
- Decode: NUM_S=3, S_W=2; addr=0xC000_0000 → sel=3, decerr=1; addr=0x8000_0000 → sel=2, decerr=0. Changing addr during GRANT leaves sel unchanged.
- Abort and reset: drop req0 during GRANT with no slv_ready → grant clears, counter unchanged, ptr advances. Assert rst mid-GRANT → all outputs 0 asynchronously.
